// File: rtl/tm1638_display_arbiter.sv
// Round-robin arbiter sharing one TM1638 driver between NUM_SOURCES frame producers.
// Latency: frame captured at edge E is issued at E+1 at the earliest; o_Valid is a 1-cycle strobe.
// Backpressure: one buffered frame per source (latest wins); issue waits for i_Busy low, busy-rise timeout.
module tm1638_display_arbiter #(
    parameter int NUM_SOURCES  = 2,
    parameter int BUSY_TIMEOUT = 15,
    localparam int GW = (NUM_SOURCES > 2) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic                                 i_Clk,
    input  logic                                 i_Rst,
    input  logic [NUM_SOURCES-1:0][7:0][7:0]     i_Segments,
    input  logic [NUM_SOURCES-1:0][7:0]          i_Leds,
    input  logic [NUM_SOURCES-1:0]               i_Valid,
    input  logic                                 i_Busy,
    output logic [7:0][7:0]                      o_Segments,
    output logic [7:0]                           o_Leds,
    output logic                                 o_Valid,
    output logic [GW-1:0]                        o_Grant,
    output logic [NUM_SOURCES-1:0]               o_Pending,
    output logic [NUM_SOURCES-1:0]               o_Overwrite,
    output logic                                 o_Timeout
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

    state_t                             state, state_nxt;
    logic [7:0]                         cnt, cnt_nxt;
    logic [GW-1:0]                      r_Last;
    logic [GW-1:0]                      win;
    logic                               issue;
    logic                               tout_nxt;
    logic [NUM_SOURCES-1:0]             gnt;
    logic [NUM_SOURCES-1:0][7:0][7:0]   seg_buf;
    logic [NUM_SOURCES-1:0][7:0]        led_buf;

    // First pending source after r_Last, wrapping; the i=NUM_SOURCES pass covers r_Last itself.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_SOURCES-1:0] req,
                                              input logic [GW-1:0]          last);
        logic [GW-1:0] w;
        int            idx;
        w = last;
        for (int i = NUM_SOURCES; i >= 1; i--) begin
            idx = int'(last) + i;
            if (idx >= NUM_SOURCES) idx = idx - NUM_SOURCES;
            if (req[idx[GW-1:0]]) w = idx[GW-1:0];
        end
        return w;
    endfunction

    assign win     = rr_pick(o_Pending, r_Last);
    assign o_Valid = (state == S_ISSUE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        issue     = 1'b0;
        tout_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (|o_Pending && !i_Busy) begin
                    issue     = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (i_Busy) begin
                    state_nxt = S_WAIT_DONE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                    if (cnt_nxt == 8'(BUSY_TIMEOUT)) begin
                        tout_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!i_Busy) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        gnt = '0;
        for (int k = 0; k < NUM_SOURCES; k++)
            gnt[k] = issue && (win == GW'(k));
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            r_Last      <= GW'(NUM_SOURCES - 1);
            o_Segments  <= '0;
            o_Leds      <= '0;
            o_Grant     <= '0;
            o_Pending   <= '0;
            o_Overwrite <= '0;
            o_Timeout   <= 1'b0;
            seg_buf     <= '0;
            led_buf     <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            o_Timeout   <= tout_nxt;
            // A capture on the granting edge re-pends without counting as an overwrite.
            o_Pending   <= (o_Pending & ~gnt) | i_Valid;
            o_Overwrite <= i_Valid & o_Pending & ~gnt;
            for (int k = 0; k < NUM_SOURCES; k++) begin
                if (i_Valid[k]) begin
                    seg_buf[k] <= i_Segments[k];
                    led_buf[k] <= i_Leds[k];
                end
            end
            if (issue) begin
                o_Segments <= seg_buf[win];
                o_Leds     <= led_buf[win];
                o_Grant    <= win;
                r_Last     <= win;
            end
        end
    end

endmodule
